cache_control: RTL and testbench
================================

# cache_control

Sequencing FSM for the 2-way set-associative, write-back, write-allocate cache datapath (16-bit addresses, 8-bit tag, 4-bit index, 128-bit lines). It takes the CPU-side request (`cache_read`/`cache_write`) and the datapath status (hit, LRU, dirty). It drives every datapath load/select strobe and runs the physical-memory handshake for write-back and line fill. It also keeps saturating hit/miss counters for performance measurement.

## Interface
- Parameters:
- CNT_WIDTH, 16, width of the hit/miss counters.
- Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cache_read  in  1  CPU read request; held until `cache_resp`.
- cache_write  in  1  CPU write request; held until `cache_resp`.
- way1_hit, way2_hit  in  1 each  tag match AND valid, per way.
- read_hit, write_hit  in  1 each  hit qualified by request type.
- LRU_out  in  1  LRU bit of indexed set (0 = way 1 is victim, 1 = way 2 is victim).
- dirty_out  in  1  dirty bit of the LRU (victim) way.
- mem_resp  in  1  physical memory transaction complete (one-cycle pulse).
- R_W  out  1  0 = fill path (`mem_rdata`, CPU address); 1 = CPU write data / victim address.
- load_data_1, load_data_2  out  1 each  write data/tag/valid arrays of the way.
- dirty_bit  out  1  value written to the dirty array.
- load_dirty_1, load_dirty_2  out  1 each  write the dirty array of the way.
- load_LRU, LRU_in  out  1 each  LRU update strobe and value.
- mem_read, mem_write  out  1 each  physical memory request; held until `mem_resp`.
- cache_resp  out  1  CPU request complete.
- hit_count, miss_count  out  CNT_WIDTH each  saturating performance counters.

## Operation
- States: IDLE, WRITE_BACK, ALLOCATE. Reset state is IDLE.
- Every output not listed for a state is 0 in that state.
- IDLE, no request: all strobes 0.
- IDLE, read hit:
  - `cache_resp` = 1.
  - `load_LRU` = 1, with `LRU_in` = `way1_hit` (the other way becomes LRU).
- IDLE, write hit:
  - `R_W` = 1.
  - `load_data_x` = 1 and `load_dirty_x` = 1 for the hit way x, with `dirty_bit` = 1.
  - LRU update as for a read hit; `cache_resp` = 1.
- IDLE, request and no hit: go to WRITE_BACK if `dirty_out` = 1, otherwise to ALLOCATE. `miss_count` increments.
- WRITE_BACK: `R_W` = 1 and `mem_write` = 1, which puts the victim address {tag_out, index, 0000} on the memory bus. On `mem_resp`, go to ALLOCATE.
- ALLOCATE: `R_W` = 0 and `mem_read` = 1. On `mem_resp`:
  - `load_data_v` = 1 and `load_dirty_v` = 1 for victim way v (way 1 if `LRU_out` = 0, else way 2), with `dirty_bit` = 0.
  - Go to IDLE.
- Return to IDLE after a fill: the request is still held, so it now hits and completes through the normal hit path. LRU and dirty updates are therefore identical for hit and miss traffic.
- Counters:
  - A miss flag is set on a miss transition and cleared on `cache_resp`.
  - `hit_count` increments on `cache_resp` only when the miss flag is clear.
  - Both counters saturate at all-ones and never wrap.
- `cache_read` and `cache_write` asserted together is a protocol violation. The controller treats it as a read; no array is written.
- Request dropped during WRITE_BACK or ALLOCATE: the memory transaction still runs to completion, the fill is still written, then the FSM returns to IDLE and stays idle.
- `mem_resp` in IDLE is ignored.

## Timing
- Reset (synchronous, checked at the clock edge): state = IDLE, miss flag = 0, `hit_count` = `miss_count` = 0. All outputs are 0 in the cycle after the reset edge.
- Reset during WRITE_BACK or ALLOCATE: aborts the transaction. `mem_read`/`mem_write` drop in the cycle after the edge. No partial line is written. Array contents are untouched.
- Output type: IDLE outputs are Mealy (a combinational function of the request and hit inputs). WRITE_BACK and ALLOCATE outputs are Moore, except the fill strobes, which are gated by `mem_resp`.
- Latencies (counted from the first cycle the request is seen in IDLE):
  - Hit: `cache_resp` in the same cycle.
  - Clean miss: 1 + N_fill + 1 cycles.
  - Dirty miss: 1 + N_wb + N_fill + 1 cycles.
  - N_wb and N_fill are each the memory latency including the `mem_resp` cycle.
- `mem_read` and `mem_write` are never both 1.
- `cache_resp` is 1 for exactly one cycle per completed request.
- Back-to-back requests: a new request may be presented in the cycle after `cache_resp` and is evaluated immediately.

## Test plan
- Reset, then read 0x1234 into an empty cache; memory answers after 3 cycles. Required: `mem_read` high 3 cycles with `R_W` = 0; `load_data_1` pulses with `dirty_bit` = 0; `cache_resp` 1 cycle later; then `miss_count` = 1, `hit_count` = 0, `LRU_in` = 1.
- Read 0x1234 again. Required: `cache_resp` in the same cycle, no `mem_read`, `hit_count` = 1.
- Write 0x1236 (hit on way 1). Required: `R_W` = 1, `load_data_1` = `load_dirty_1` = 1 with `dirty_bit` = 1, `cache_resp` in the same cycle.
- Fill way 2 with tag 0x56, then read tag 0x78 at the same index (victim way 1, dirty). Required: WRITE_BACK with `mem_write` and `R_W` = 1 until `mem_resp`, then ALLOCATE with `mem_read`, then `load_data_1` on the fill.
- Assert `reset` on the second cycle of ALLOCATE. Required: `mem_read` = 0 next cycle, no `load_data_*` pulse, counters = 0, state = IDLE.
- Force `miss_count` to 0xFFFF (or run 65536 misses) and miss once more. Required: `miss_count` stays 0xFFFF.

Source files
------------

// File: rtl/cache_control.sv
// cache_control: sequencing FSM for a 2-way set-associative, write-back,
// write-allocate cache. It decodes the CPU request against the datapath hit,
// LRU and dirty status. It drives the datapath load/select strobes and the
// physical-memory handshake, and keeps saturating hit/miss counters.
module cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cache_read,
  input  logic                 cache_write,
  input  logic                 way1_hit,
  input  logic                 way2_hit,
  input  logic                 read_hit,
  input  logic                 write_hit,
  input  logic                 LRU_out,
  input  logic                 dirty_out,
  input  logic                 mem_resp,
  output logic                 R_W,
  output logic                 load_data_1,
  output logic                 load_data_2,
  output logic                 dirty_bit,
  output logic                 load_dirty_1,
  output logic                 load_dirty_2,
  output logic                 load_LRU,
  output logic                 LRU_in,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 cache_resp,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } state_t;

  state_t                 state_reg;
  logic                   miss_flag_reg;
  logic [CNT_WIDTH-1:0]   hit_count_reg;
  logic [CNT_WIDTH-1:0]   miss_count_reg;

  logic       request;
  logic       rd_hit;
  logic       wr_hit;
  logic       any_hit;
  logic       miss;
  logic [1:0] way_hit_vec;
  logic [1:0] victim_vec;
  logic [1:0] load_data_vec;
  logic [1:0] load_dirty_vec;

  // Request decode; a simultaneous read and write is handled as a read, so the
  // write path is qualified with the absence of a read.
  always_comb begin
    request     = cache_read | cache_write;
    rd_hit      = cache_read & read_hit;
    wr_hit      = cache_write & ~cache_read & write_hit;
    any_hit     = rd_hit | wr_hit;
    miss        = request & ~any_hit;
    way_hit_vec = {way2_hit, way1_hit};
    victim_vec  = {LRU_out, ~LRU_out};
  end

  // Per-way array strobes: the hit way on a write hit, the victim way when the
  // fill data arrives.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
      assign load_data_vec[gi]  = ((state_reg == IDLE) & wr_hit & way_hit_vec[gi]) |
                                  ((state_reg == ALLOCATE) & mem_resp & victim_vec[gi]);
      assign load_dirty_vec[gi] = load_data_vec[gi];
    end
  endgenerate

  assign load_data_1  = load_data_vec[0];
  assign load_data_2  = load_data_vec[1];
  assign load_dirty_1 = load_dirty_vec[0];
  assign load_dirty_2 = load_dirty_vec[1];
  assign hit_count    = hit_count_reg;
  assign miss_count   = miss_count_reg;

  // Remaining outputs: Mealy on the request in IDLE, Moore in the memory states.
  always_comb begin
    R_W        = 1'b0;
    dirty_bit  = 1'b0;
    load_LRU   = 1'b0;
    LRU_in     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    cache_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_hit) begin
          cache_resp = 1'b1;
          load_LRU   = 1'b1;
          LRU_in     = way1_hit;
          R_W        = wr_hit;
          dirty_bit  = wr_hit;
        end
      end
      WRITE_BACK: begin
        R_W       = 1'b1;
        mem_write = 1'b1;
      end
      ALLOCATE: begin
        mem_read = 1'b1;
      end
      default: ;
    endcase
  end

  // State sequencing, miss flag and saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      miss_flag_reg  <= 1'b0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (miss) begin
            state_reg <= dirty_out ? WRITE_BACK : ALLOCATE;
          end
        end
        WRITE_BACK: begin
          if (mem_resp) begin
            state_reg <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mem_resp) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (state_reg == IDLE && miss) begin
        miss_flag_reg <= 1'b1;
        if (miss_count_reg != '1) begin
          miss_count_reg <= miss_count_reg + 1'b1;
        end
      end

      if (cache_resp) begin
        miss_flag_reg <= 1'b0;
        if (!miss_flag_reg && hit_count_reg != '1) begin
          hit_count_reg <= hit_count_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: drives cache_control with a transaction-level cache model
// (tags, valid, dirty, LRU per set) that plans every cycle's inputs and the
// outputs those inputs must produce. One compare process checks each cycle.
module tb_cache_control;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cache_read = 1'b0, cache_write = 1'b0;
  logic          way1_hit = 1'b0, way2_hit = 1'b0;
  logic          read_hit = 1'b0, write_hit = 1'b0;
  logic          LRU_out = 1'b0, dirty_out = 1'b0, mem_resp = 1'b0;
  logic          R_W, load_data_1, load_data_2, dirty_bit;
  logic          load_dirty_1, load_dirty_2, load_LRU, LRU_in;
  logic          mem_read, mem_write, cache_resp;
  logic [CW-1:0] hit_count, miss_count;

  cache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .cache_read(cache_read), .cache_write(cache_write),
    .way1_hit(way1_hit), .way2_hit(way2_hit),
    .read_hit(read_hit), .write_hit(write_hit),
    .LRU_out(LRU_out), .dirty_out(dirty_out), .mem_resp(mem_resp),
    .R_W(R_W), .load_data_1(load_data_1), .load_data_2(load_data_2),
    .dirty_bit(dirty_bit), .load_dirty_1(load_dirty_1), .load_dirty_2(load_dirty_2),
    .load_LRU(load_LRU), .LRU_in(LRU_in),
    .mem_read(mem_read), .mem_write(mem_write), .cache_resp(cache_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          chk;
    logic [10:0]   outs;
    logic [CW-1:0] hc;
    logic [CW-1:0] mc;
  } exp_t;

  exp_t exp_q[$];

  // Reference cache model
  logic [7:0] m_tag   [2][16];
  logic       m_valid [2][16];
  logic       m_dirty [2][16];
  logic       m_lru   [16];
  int         m_hc, m_mc;
  bit         m_flag;

  int vectors = 0, miscompares = 0;
  int rd_cycles = 0, wr_cycles = 0;

  exp_t        e;
  logic [10:0] act;

  function automatic logic [10:0] pack(input logic rw, ld1, ld2, db, dd1, dd2,
                                       llru, lin, mr, mw, resp);
    return {rw, ld1, ld2, db, dd1, dd2, llru, lin, mr, mw, resp};
  endfunction

  function automatic int sat(input int x);
    return (x >= CMAX) ? x : x + 1;
  endfunction

  task automatic check(input string name, input int actual, input int required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  // One clock cycle of stimulus plus the outputs it must produce.
  task automatic step(input logic rst, rd, wr, w1, w2, lru, drt, resp, chk,
                      input logic [10:0] outs);
    @(posedge clk);
    #1;
    reset       = rst;
    cache_read  = rd;
    cache_write = wr;
    way1_hit    = w1;
    way2_hit    = w2;
    read_hit    = rd & (w1 | w2);
    write_hit   = wr & (w1 | w2);
    LRU_out     = lru;
    dirty_out   = drt;
    mem_resp    = resp;
    exp_q.push_back('{chk, outs, CW'(m_hc), CW'(m_mc)});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 1'b1, 11'd0);
  endtask

  task automatic hit_cycle(input logic rd, wr, w1, w2, input logic [3:0] idx);
    logic is_wr;
    is_wr = wr & ~rd;
    step(1'b0, rd, wr, w1, w2, m_lru[idx], m_dirty[m_lru[idx]][idx],
         1'($urandom_range(0, 1)), 1'b1,
         pack(is_wr, is_wr & w1, is_wr & w2, is_wr, is_wr & w1, is_wr & w2,
              1'b1, w1, 1'b0, 1'b0, 1'b1));
    m_lru[idx] = w1;
    if (is_wr) m_dirty[w2 ? 1 : 0][idx] = 1'b1;
    if (!m_flag) m_hc = sat(m_hc);
    m_flag = 1'b0;
  endtask

  task automatic do_req(input logic [15:0] addr, input logic rd, wr, drop,
                        input int nwb, nfill);
    logic [3:0] idx;
    logic [7:0] tg;
    logic       w1, w2, v, d, last;
    idx = addr[7:4];
    tg  = addr[15:8];
    w1  = m_valid[0][idx] && (m_tag[0][idx] == tg);
    w2  = m_valid[1][idx] && (m_tag[1][idx] == tg);
    v   = m_lru[idx];
    d   = m_dirty[v][idx];
    if (w1 || w2) begin
      hit_cycle(rd, wr, w1, w2, idx);
    end else begin
      step(1'b0, rd, wr, 1'b0, 1'b0, v, d, 1'($urandom_range(0, 1)), 1'b1, 11'd0);
      m_mc   = sat(m_mc);
      m_flag = 1'b1;
      if (drop) begin
        rd = 1'b0;
        wr = 1'b0;
      end
      if (d) begin
        for (int k = 0; k < nwb; k++)
          step(1'b0, rd, wr, 1'b0, 1'b0, v, d, 1'(k == nwb - 1), 1'b1,
               pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      end
      for (int k = 0; k < nfill; k++) begin
        last = 1'(k == nfill - 1);
        step(1'b0, rd, wr, 1'b0, 1'b0, v, d, last, 1'b1,
             pack(1'b0, last & ~v, last & v, 1'b0, last & ~v, last & v,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      end
      m_tag[v][idx]   = tg;
      m_valid[v][idx] = 1'b1;
      m_dirty[v][idx] = 1'b0;
      if (!drop) hit_cycle(rd, wr, ~v, v, idx);
    end
  endtask

  task automatic random_traffic(input int n);
    int r;
    logic [15:0] a;
    for (int t = 0; t < n; t++) begin
      r = $urandom_range(0, 9);
      a = {8'h10 + 8'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      do_req(a, r < 5 || r == 9, r >= 5, $urandom_range(0, 7) == 0,
             $urandom_range(1, 4), $urandom_range(1, 4));
      for (int g = $urandom_range(0, 2); g > 0; g--) idle();
    end
  endtask

  // Compare DUT outputs with the planned expectation once per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (mem_read) rd_cycles++;
      if (mem_write) wr_cycles++;
      if (e.chk) begin
        act = {R_W, load_data_1, load_data_2, dirty_bit, load_dirty_1, load_dirty_2,
               load_LRU, LRU_in, mem_read, mem_write, cache_resp};
        vectors++;
        if (act !== e.outs) begin
          miscompares++;
          $display("FAIL strobes @%0t: got %b, required %b (RW ld1 ld2 db dd1 dd2 lL Lin mr mw resp)",
                   $time, act, e.outs);
        end
        vectors++;
        if ({hit_count, miss_count} !== {e.hc, e.mc}) begin
          miscompares++;
          $display("FAIL counters @%0t: got hit=%0d miss=%0d, required hit=%0d miss=%0d",
                   $time, hit_count, miss_count, e.hc, e.mc);
        end
      end
    end
  end

  initial begin
    logic [3:0] ri;
    logic       rv, rd_d;
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 16; s++) begin
        m_tag[w][s]   = 8'h00;
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
      end
    for (int s = 0; s < 16; s++) m_lru[s] = 1'b0;
    m_hc = 0; m_mc = 0; m_flag = 1'b0;

    // Reset, then all outputs quiet.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    idle();

    // Directed sequence with hand-computed results.
    do_req(16'h1234, 1'b1, 1'b0, 1'b0, 1, 3);
    idle();
    @(negedge clk); #2;
    check("first_fill_mem_read_cycles", rd_cycles, 3);
    check("first_fill_miss_count", miss_count, 1);
    check("first_fill_hit_count", hit_count, 0);

    do_req(16'h1234, 1'b1, 1'b0, 1'b0, 1, 1);
    idle();
    @(negedge clk); #2;
    check("reread_hit_count", hit_count, 1);
    check("reread_no_mem_read", rd_cycles, 3);

    do_req(16'h1236, 1'b0, 1'b1, 1'b0, 1, 1);
    do_req(16'h5634, 1'b1, 1'b0, 1'b0, 1, 2);
    do_req(16'h7834, 1'b1, 1'b0, 1'b0, 3, 2);
    idle();
    @(negedge clk); #2;
    check("dirty_miss_write_back_cycles", wr_cycles, 3);
    check("dirty_miss_mem_read_total", rd_cycles, 7);
    check("dirty_miss_miss_count", miss_count, 3);
    check("dirty_miss_hit_count", hit_count, 2);

    random_traffic(150);
    idle();
    @(negedge clk); #2;
    check("miss_count_saturated", miss_count, CMAX);

    // Reset on the second ALLOCATE cycle of a miss.
    ri   = 4'd5;
    rv   = m_lru[ri];
    rd_d = m_dirty[rv][ri];
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rv, rd_d, 1'b0, 1'b1, 11'd0);
    m_mc = sat(m_mc);
    m_flag = 1'b1;
    if (rd_d)
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rv, rd_d, 1'b1, 1'b1,
           pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rv, rd_d, 1'b0, 1'b1,
         pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rv, rd_d, 1'b0, 1'b1,
         pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    m_hc = 0; m_mc = 0; m_flag = 1'b0;
    idle();
    @(negedge clk); #2;
    check("reset_in_allocate_mem_read", mem_read, 0);
    check("reset_in_allocate_miss_count", miss_count, 0);
    check("reset_in_allocate_hit_count", hit_count, 0);

    random_traffic(60);
    idle();
    idle();
    @(negedge clk); #2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
